updown_mod_counter: RTL and testbench
=====================================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
Parameters, one per line: name, default, meaning.
REQ-001 The block SHALL have parameter WIDTH, default 4: counter width in bits (minimum 1).
REQ-002 The block SHALL have parameter PRESCALE, default 1: the count steps once per PRESCALE enabled cycles (minimum 1).
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = wrap at the boundary, 1 = hold at the boundary.

Ports, one per line: name, direction, width, meaning.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1: count enable; also advances the prescaler.
REQ-007 The block SHALL have port up, input, 1: direction; 1 = up, 0 = down.
REQ-008 The block SHALL have port load, input, 1: synchronous load strobe.
REQ-009 The block SHALL have port load_val, input, WIDTH: value to load.
REQ-010 The block SHALL have port max_val, input, WIDTH: upper bound, so the count range is 0..max_val.
REQ-011 The block SHALL have port Q, output, WIDTH: registered count value.
REQ-012 The block SHALL have port tc, output, 1: registered terminal-count pulse.

Function
REQ-013 Priority SHALL be reset > load > step > hold.
REQ-014 On load, the next state SHALL be Q <= min(load_val, max_val), the prescaler SHALL clear to 0, and tc SHALL be 0.
REQ-015 A step SHALL occur only in cycles where en=1 and the prescaler tick is asserted; with PRESCALE=1, tick = en.
REQ-016 Up step: if Q >= max_val, Q SHALL go to 0 when SATURATE=0 or to max_val when SATURATE=1; otherwise Q SHALL go to Q+1.
REQ-017 Down step: if Q == 0, Q SHALL go to max_val when SATURATE=0 or stay 0 when SATURATE=1; if Q > max_val, Q SHALL go to max_val; otherwise Q SHALL go to Q-1.
REQ-018 tc SHALL be 1 for exactly the one cycle following each step taken at a boundary (up with Q >= max_val, down with Q == 0), in both modes; otherwise tc SHALL be 0.
REQ-019 With en=0, Q and the prescaler SHALL hold and tc SHALL be 0 on the following cycle.
REQ-020 max_val=0 SHALL keep Q at 0 and assert tc after every step.
REQ-021 A change of up or max_val SHALL take effect on the next step with no pipeline delay.
REQ-022 The latency from step to new Q SHALL be one clock edge.
REQ-023 Arithmetic SHALL be WIDTH bits wide with no overflow beyond the WIDTH-bit range (max_val = 2^WIDTH-1 gives a natural binary wrap).

Reset
REQ-024 While reset=1, the outputs SHALL be Q=0 and tc=0 and the prescaler count SHALL be 0, asynchronously and without any clock edge.
REQ-025 Assertion of reset mid-count or mid-prescale SHALL discard all state immediately.
REQ-026 After reset deasserts, the first step SHALL require a full PRESCALE enabled cycles.

Structure
REQ-027 A shared package/header counter_pkg SHALL hold the direction encodings DIR_UP=1 and DIR_DOWN=0, the mode constants MODE_WRAP=0 and MODE_SAT=1, and the parameter defaults.
REQ-028 The prescaler SHALL be the sub-module tick_prescaler, with parameter N and ports clk, reset, en, clr and tick (tick = en AND count==N-1; count wraps to 0 on tick and clears on clr).
REQ-029 The remaining logic SHALL be a single next-state block plus the registers for Q and tc.

Verification (WIDTH=4, max_val=9 unless stated)
REQ-030 Down wrap: release reset, en=1, up=0 -> Q sequence 0,9,8,...,1,0,9; tc=1 in the cycle after each 0->9 step.
REQ-031 Up wrap: en=1, up=1 -> Q sequence 0,1,...,9,0; tc high for one cycle after the 9->0 step; with max_val=15 -> 15 wraps to 0.
REQ-032 Saturate (SATURATE=1), up=1 -> Q reaches 9 and holds; tc=1 after every step at 9; switching to up=0 -> Q goes 8 with tc=0.
REQ-033 Load: load_val=12 -> Q=9; load_val=5 with load=1 and en=1 in the same cycle -> Q=5 (load wins), tc=0.
REQ-034 Prescale (PRESCALE=3), up=1, en=1 -> Q increments every 3rd cycle; en low for 2 cycles mid-period -> the period stretches by 2 cycles.
REQ-035 Async reset: assert reset between clock edges with Q=7 -> Q=0 and tc=0 before the next edge; counting restarts from 0 after release.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter: direction and
// saturation-mode encodings, plus the default parameter values.
package counter_pkg;

    // Encodings for the up input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Encodings for the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Default parameter values
    localparam int DEFAULT_WIDTH    = 4;
    localparam int DEFAULT_PRESCALE = 1;
    localparam int DEFAULT_SATURATE = MODE_WRAP;

endpackage : counter_pkg

// File: rtl/tick_prescaler.sv
// Enable prescaler: tick is asserted on every Nth enabled cycle.
// The count wraps to 0 on tick and is forced to 0 by clr.
// With N=1, tick simply follows en.
module tick_prescaler #(
    parameter int N = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The tick is combinational, so a step happens in the same cycle the last enabled cycle arrives
    assign tick = en && (count_q == LAST);

    // Next count: clr dominates, then wrap on tick, then advance on en
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned, which would infer a latch.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments here, so every register samples its pre-edge inputs.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/updown_mod_counter.sv
// Up/down counter over the range 0..max_val with synchronous load, an
// enable prescaler, wrap or saturate behaviour at the range ends, and a
// registered one-cycle terminal-count pulse after each boundary step.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int SATURATE = DEFAULT_SATURATE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             tc_d;
    logic             tick;

    // A load restarts the prescale period so the next step needs a full PRESCALE enabled cycles
    tick_prescaler #(
        .N (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );

    // Next-state: load beats step beats hold; tc flags a step taken at a range end
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (load) begin
            q_d = (load_val > max_val) ? max_val : load_val;
        end else if (tick) begin
            if (up == DIR_UP) begin
                if (q_q >= max_val) begin
                    q_d  = (SATURATE == MODE_SAT) ? max_val : '0;
                    tc_d = 1'b1;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (q_q == '0) begin
                    q_d  = (SATURATE == MODE_SAT) ? '0 : max_val;
                    tc_d = 1'b1;
                end else if (q_q > max_val) begin
                    // max_val was lowered beneath the count: re-enter the range from the top
                    q_d = max_val;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    // Count and terminal-count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign Q  = q_q;
    assign tc = tc_q;

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter. Three instances share one set of
// inputs: wrap mode, saturate mode, and wrap mode with PRESCALE=3.
module tb_updown_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] max_val;

    logic [3:0] q_wrap, q_sat, q_pre;
    logic       tc_wrap, tc_sat, tc_pre;

    int errors = 0;
    int checks = 0;

    updown_mod_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val), .Q(q_wrap), .tc(tc_wrap)
    );

    updown_mod_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val), .Q(q_sat), .tc(tc_sat)
    );

    updown_mod_counter #(.WIDTH(4), .PRESCALE(3), .SATURATE(0)) u_pre (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val), .Q(q_pre), .tc(tc_pre)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Advance one rising edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between clock edges
    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (q_wrap !== 4'd0) begin errors++; $display("FAIL reset q_wrap: got %0d required 0", q_wrap); end
        checks++;
        if (tc_wrap !== 1'b0) begin errors++; $display("FAIL reset tc_wrap: got %b required 0", tc_wrap); end
        checks++;
        if (q_sat !== 4'd0) begin errors++; $display("FAIL reset q_sat: got %0d required 0", q_sat); end
        checks++;
        if (q_pre !== 4'd0) begin errors++; $display("FAIL reset q_pre: got %0d required 0", q_pre); end
        reset = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [3:0] exp_q;
        logic       exp_tc;
        apply_reset();
        max_val = 4'd9; up = 1'b0; en = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            exp_q  = 4'(9 - ((i - 1) % 10));
            exp_tc = (i == 1) || (i == 11);
            checks++;
            if (q_wrap !== exp_q) begin errors++; $display("FAIL down_wrap q step %0d: got %0d required %0d", i, q_wrap, exp_q); end
            checks++;
            if (tc_wrap !== exp_tc) begin errors++; $display("FAIL down_wrap tc step %0d: got %b required %b", i, tc_wrap, exp_tc); end
        end
        en = 1'b0;
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp_q;
        logic       exp_tc;
        apply_reset();
        max_val = 4'd9; up = 1'b1; en = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            exp_q  = 4'(i % 10);
            exp_tc = (i == 10);
            checks++;
            if (q_wrap !== exp_q) begin errors++; $display("FAIL up_wrap q step %0d: got %0d required %0d", i, q_wrap, exp_q); end
            checks++;
            if (tc_wrap !== exp_tc) begin errors++; $display("FAIL up_wrap tc step %0d: got %b required %b", i, tc_wrap, exp_tc); end
        end
        // Full-range wrap with max_val = 15
        max_val = 4'd15; load_val = 4'd14; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (q_wrap !== 4'd14) begin errors++; $display("FAIL up_wrap15 load: got %0d required 14", q_wrap); end
        step();
        checks++;
        if (q_wrap !== 4'd15 || tc_wrap !== 1'b0) begin errors++; $display("FAIL up_wrap15 to15: got q=%0d tc=%b required q=15 tc=0", q_wrap, tc_wrap); end
        step();
        checks++;
        if (q_wrap !== 4'd0 || tc_wrap !== 1'b1) begin errors++; $display("FAIL up_wrap15 to0: got q=%0d tc=%b required q=0 tc=1", q_wrap, tc_wrap); end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        logic [3:0] exp_q;
        logic       exp_tc;
        apply_reset();
        max_val = 4'd9; up = 1'b1; en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_q  = (i < 9) ? 4'(i) : 4'd9;
            exp_tc = (i >= 10);
            checks++;
            if (q_sat !== exp_q) begin errors++; $display("FAIL saturate q step %0d: got %0d required %0d", i, q_sat, exp_q); end
            checks++;
            if (tc_sat !== exp_tc) begin errors++; $display("FAIL saturate tc step %0d: got %b required %b", i, tc_sat, exp_tc); end
        end
        up = 1'b0;
        step();
        checks++;
        if (q_sat !== 4'd8 || tc_sat !== 1'b0) begin errors++; $display("FAIL saturate reverse: got q=%0d tc=%b required q=8 tc=0", q_sat, tc_sat); end
        en = 1'b0;
    endtask

    task automatic test_load();
        apply_reset();
        max_val = 4'd9; en = 1'b0; load = 1'b1; load_val = 4'd12;
        step();
        checks++;
        if (q_wrap !== 4'd9 || tc_wrap !== 1'b0) begin errors++; $display("FAIL load clamp: got q=%0d tc=%b required q=9 tc=0", q_wrap, tc_wrap); end
        // Load with en high at the top boundary: the wrap and its tc are suppressed
        load_val = 4'd5; en = 1'b1; up = 1'b1;
        step();
        checks++;
        if (q_wrap !== 4'd5 || tc_wrap !== 1'b0) begin errors++; $display("FAIL load over step: got q=%0d tc=%b required q=5 tc=0", q_wrap, tc_wrap); end
        load = 1'b0; en = 1'b0;
        step();
        checks++;
        if (q_wrap !== 4'd5 || tc_wrap !== 1'b0) begin errors++; $display("FAIL load hold: got q=%0d tc=%b required q=5 tc=0", q_wrap, tc_wrap); end
    endtask

    task automatic test_prescale();
        logic [3:0] exp_tab [11];
        exp_tab = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
        apply_reset();
        max_val = 4'd9; up = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            en = !((e == 8) || (e == 9));
            step();
            checks++;
            if (q_pre !== exp_tab[e-1] || tc_pre !== 1'b0) begin
                errors++;
                $display("FAIL prescale edge %0d: got q=%0d tc=%b required q=%0d tc=0", e, q_pre, tc_pre, exp_tab[e-1]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        max_val = 4'd9; en = 1'b0; load = 1'b1; load_val = 4'd6;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        checks++;
        if (q_wrap !== 4'd7) begin errors++; $display("FAIL async pre q_wrap: got %0d required 7", q_wrap); end
        checks++;
        if (q_pre !== 4'd6) begin errors++; $display("FAIL async pre q_pre: got %0d required 6", q_pre); end
        // Mid-cycle, well before the next edge
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (q_wrap !== 4'd0 || tc_wrap !== 1'b0) begin errors++; $display("FAIL async clear wrap: got q=%0d tc=%b required q=0 tc=0", q_wrap, tc_wrap); end
        checks++;
        if (q_pre !== 4'd0) begin errors++; $display("FAIL async clear pre: got %0d required 0", q_pre); end
        #1;
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (q_wrap !== 4'(i)) begin errors++; $display("FAIL async restart wrap %0d: got %0d required %0d", i, q_wrap, i); end
            checks++;
            if (q_pre !== ((i == 3) ? 4'd1 : 4'd0)) begin errors++; $display("FAIL async restart pre %0d: got %0d required %0d", i, q_pre, (i == 3) ? 1 : 0); end
        end
        en = 1'b0;
    endtask

    task automatic test_zero_max();
        apply_reset();
        max_val = 4'd0; en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) up = 1'b0;
            step();
            checks++;
            if (q_wrap !== 4'd0 || tc_wrap !== 1'b1) begin errors++; $display("FAIL zero_max wrap %0d: got q=%0d tc=%b required q=0 tc=1", i, q_wrap, tc_wrap); end
            checks++;
            if (q_sat !== 4'd0 || tc_sat !== 1'b1) begin errors++; $display("FAIL zero_max sat %0d: got q=%0d tc=%b required q=0 tc=1", i, q_sat, tc_sat); end
        end
        en = 1'b0;
    endtask

    task automatic test_max_change();
        apply_reset();
        max_val = 4'd9; load = 1'b1; load_val = 4'd9;
        step();
        load = 1'b0;
        // Lower the bound below the count, then step down
        max_val = 4'd5; up = 1'b0; en = 1'b1;
        step();
        checks++;
        if (q_wrap !== 4'd5 || tc_wrap !== 1'b0) begin errors++; $display("FAIL max_change down: got q=%0d tc=%b required q=5 tc=0", q_wrap, tc_wrap); end
        // Lower again and step up from above the bound
        max_val = 4'd3; up = 1'b1;
        step();
        checks++;
        if (q_wrap !== 4'd0 || tc_wrap !== 1'b1) begin errors++; $display("FAIL max_change up: got q=%0d tc=%b required q=0 tc=1", q_wrap, tc_wrap); end
        en = 1'b0;
        step();
        checks++;
        if (q_wrap !== 4'd0 || tc_wrap !== 1'b0) begin errors++; $display("FAIL max_change idle: got q=%0d tc=%b required q=0 tc=0", q_wrap, tc_wrap); end
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = 4'd0;
        max_val  = 4'd9;
        test_reset();
        test_down_wrap();
        test_up_wrap();
        test_saturate();
        test_load();
        test_prescale();
        test_async_reset();
        test_zero_max();
        test_max_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_updown_mod_counter
